// File: rtl/alu_mul_sequencer_if.sv
// Handshake and ALU-drive bundle between the core control unit, the
// multiply sequencer and the shared ALU.
interface alu_mul_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] product;
  logic [3:0]      alu_op;
  logic [XLEN-1:0] alu_i1;
  logic [XLEN-1:0] alu_i2;
  logic [XLEN-1:0] alu_out;

  // Sequencer side
  modport slave (
    input  start, a, b, alu_out,
    output busy, done, product, alu_op, alu_i1, alu_i2
  );

  // Core control unit / ALU side
  modport master (
    output start, a, b, alu_out,
    input  busy, done, product, alu_op, alu_i1, alu_i2
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 (low half) multiplier that borrows the shared ALU for
// its ADD and SLL steps. Fixed latency: done pulses 2*XLEN+1 cycles after the
// accepting edge.
module alu_mul_sequencer #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned OP_ADD = 0,
  parameter int unsigned OP_SLL = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_mul_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] product_q, product_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Next-state, register updates and ALU drive, all decoded from state
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    bus.alu_op  = 4'(OP_ADD);
    bus.alu_i1  = '0;
    bus.alu_i2  = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = '0;
          mcand_d  = bus.a;
          mplier_d = bus.b;
          cnt_d    = '0;
          state_d  = S_ADD;
        end
      end
      S_ADD: begin
        bus.busy   = 1'b1;
        bus.alu_op = 4'(OP_ADD);
        bus.alu_i1 = acc_q;
        bus.alu_i2 = mplier_q[0] ? mcand_q : '0;
        acc_d      = bus.alu_out;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        bus.busy   = 1'b1;
        bus.alu_op = 4'(OP_SLL);
        bus.alu_i1 = mcand_q;
        bus.alu_i2 = XLEN'(1);
        mcand_d    = bus.alu_out;
        mplier_d   = mplier_q >> 1;
        cnt_d      = cnt_q + 6'd1;
        // acc already holds the final sum: the last ADD landed on the prior edge
        if (cnt_q == 6'(XLEN - 1)) begin
          product_d = acc_q;
          state_d   = S_DONE;
        end else begin
          state_d   = S_ADD;
        end
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.product = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench for alu_mul_sequencer with a behavioural ALU in the loop.
module tb_alu_mul_sequencer;

  localparam int unsigned NMAX = 140;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_mul_sequencer_if #(.XLEN(32)) bus ();

  alu_mul_sequencer #(.XLEN(32), .OP_ADD(0), .OP_SLL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural shared ALU: combinational ADD and SLL
  assign bus.alu_out = (bus.alu_op == 4'd0) ? bus.alu_i1 + bus.alu_i2 :
                       (bus.alu_op == 4'd4) ? bus.alu_i1 << bus.alu_i2[4:0] : 32'h0;

  // Per-cycle observations; cycle 1 is the first cycle after the accepting edge
  logic        rb [1:NMAX];
  logic        rd [1:NMAX];
  logic [31:0] rp [1:NMAX];
  logic [3:0]  ro [1:NMAX];
  logic [31:0] ri1[1:NMAX];
  logic [31:0] ri2[1:NMAX];
  logic        rst_busy, rst_done;
  logic [31:0] rst_prod;

  // Drive one request and record outputs for ncyc cycles. start stays high
  // through cycle start_len-1, is pulsed in cycle inj (with new operands), and
  // rst is pulsed in cycle rst_cyc (0 disables inj / rst_cyc).
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input int ncyc, input int start_len,
                        input int inj, input logic [31:0] ia, input logic [31:0] ib,
                        input int rst_cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = av;
    bus.b = bv;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      rb[n] = bus.busy;   rd[n] = bus.done;    rp[n] = bus.product;
      ro[n] = bus.alu_op; ri1[n] = bus.alu_i1; ri2[n] = bus.alu_i2;
      if (n == inj) begin
        bus.a = ia;
        bus.b = ib;
      end
      bus.start = (n < start_len) || (n == inj);
      if (n == rst_cyc) begin
        rst = 1'b1;
        #1;
        rst_busy = bus.busy; rst_done = bus.done; rst_prod = bus.product;
      end else begin
        rst = 1'b0;
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp += 6;
    if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0)     begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
    if (bus.product !== 32'h0) begin n_bad++; $display("FAIL reset_product got %h want 0", bus.product); end
    if (bus.alu_op !== 4'd0)   begin n_bad++; $display("FAIL reset_alu_op got %0d want 0", bus.alu_op); end
    if (bus.alu_i1 !== 32'h0)  begin n_bad++; $display("FAIL reset_alu_i1 got %h want 0", bus.alu_i1); end
    if (bus.alu_i2 !== 32'h0)  begin n_bad++; $display("FAIL reset_alu_i2 got %h want 0", bus.alu_i2); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL idle_no_start_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_basic;
    run_op(32'd3, 32'd5, 70, 1, 0, '0, '0, 0);
    for (int n = 1; n <= 70; n++) begin
      n_cmp += 2;
      if (rb[n] !== ((n >= 1) && (n <= 64))) begin
        n_bad++; $display("FAIL basic_busy cycle %0d got %b want %b", n, rb[n], (n <= 64));
      end
      if (rd[n] !== (n == 65)) begin
        n_bad++; $display("FAIL basic_done cycle %0d got %b want %b", n, rd[n], (n == 65));
      end
    end
    n_cmp += 3;
    if (rp[64] !== 32'h0)  begin n_bad++; $display("FAIL basic_prod_before_done got %h want 0", rp[64]); end
    if (rp[65] !== 32'd15) begin n_bad++; $display("FAIL basic_prod got %h want f", rp[65]); end
    if (rp[70] !== 32'd15) begin n_bad++; $display("FAIL basic_prod_held got %h want f", rp[70]); end
  endtask

  task automatic test_corners;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] ve [5];
    logic [31:0] prev;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF; ve[0] = 32'h0000_0001;
    va[1] = 32'h0001_0000; vb[1] = 32'h0001_0000; ve[1] = 32'h0000_0000;
    va[2] = 32'h1234_5678; vb[2] = 32'h0000_0003; ve[2] = 32'h369D_0368;
    va[3] = 32'h1234_5678; vb[3] = 32'h0000_0000; ve[3] = 32'h0000_0000;
    va[4] = 32'h0000_0000; vb[4] = 32'h9ABC_DEF0; ve[4] = 32'h0000_0000;
    prev = 32'd15;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], 70, 1, 0, '0, '0, 0);
      n_cmp += 5;
      if (rp[1] !== prev)   begin n_bad++; $display("FAIL corner%0d_prod_held_start got %h want %h", i, rp[1], prev); end
      if (rd[64] !== 1'b0)  begin n_bad++; $display("FAIL corner%0d_done_early got %b want 0", i, rd[64]); end
      if (rd[65] !== 1'b1)  begin n_bad++; $display("FAIL corner%0d_done_65 got %b want 1", i, rd[65]); end
      if (rd[66] !== 1'b0)  begin n_bad++; $display("FAIL corner%0d_done_late got %b want 0", i, rd[66]); end
      if (rp[65] !== ve[i]) begin n_bad++; $display("FAIL corner%0d_prod got %h want %h", i, rp[65], ve[i]); end
      prev = ve[i];
    end
  endtask

  task automatic test_ignore_busy;
    int dcnt = 0;
    run_op(32'h0000_1234, 32'h0000_0011, 70, 1, 10, 32'd7, 32'd9, 0);
    for (int n = 1; n <= 70; n++) if (rd[n] === 1'b1) dcnt++;
    n_cmp += 3;
    if (dcnt !== 1)              begin n_bad++; $display("FAIL ignore_done_count got %0d want 1", dcnt); end
    if (rd[65] !== 1'b1)         begin n_bad++; $display("FAIL ignore_done_65 got %b want 1", rd[65]); end
    if (rp[65] !== 32'h0001_3574) begin n_bad++; $display("FAIL ignore_prod got %h want 00013574", rp[65]); end
  endtask

  task automatic test_reset_mid;
    int dcnt = 0;
    run_op(32'h0000_00FF, 32'h0000_0101, 70, 1, 0, '0, '0, 20);
    n_cmp += 4;
    if (rp[19] !== 32'h0001_3574) begin n_bad++; $display("FAIL rstmid_prod_before got %h want 00013574", rp[19]); end
    if (rst_busy !== 1'b0)   begin n_bad++; $display("FAIL rstmid_busy got %b want 0", rst_busy); end
    if (rst_done !== 1'b0)   begin n_bad++; $display("FAIL rstmid_done got %b want 0", rst_done); end
    if (rst_prod !== 32'h0)  begin n_bad++; $display("FAIL rstmid_prod got %h want 0", rst_prod); end
    for (int n = 21; n <= 70; n++) begin
      if (rd[n] === 1'b1) dcnt++;
      n_cmp++;
      if (rb[n] !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy_after cycle %0d got %b want 0", n, rb[n]); end
    end
    n_cmp++;
    if (dcnt !== 0) begin n_bad++; $display("FAIL rstmid_done_count got %0d want 0", dcnt); end
    run_op(32'd6, 32'd7, 70, 1, 0, '0, '0, 0);
    n_cmp += 2;
    if (rd[65] !== 1'b1)  begin n_bad++; $display("FAIL rstmid_next_done got %b want 1", rd[65]); end
    if (rp[65] !== 32'd42) begin n_bad++; $display("FAIL rstmid_next_prod got %h want 2a", rp[65]); end
  endtask

  task automatic test_alu_drive;
    logic [31:0] ga, gb, mask, e_op_i1, e_i2, e_prod;
    int k;
    ga = 32'hDEAD_BEEF;
    gb = 32'h0000_A5A5;
    e_prod = ga * gb;
    run_op(ga, gb, 70, 1, 0, '0, '0, 0);
    for (int n = 1; n <= 64; n++) begin
      k = (n - 1) / 2;
      mask = (k == 0) ? 32'h0 : (32'hFFFF_FFFF >> (32 - k));
      n_cmp += 3;
      if (n % 2 == 1) begin
        e_op_i1 = ga * (gb & mask);
        e_i2 = gb[k] ? (ga << k) : 32'h0;
        if (ro[n] !== 4'd0)     begin n_bad++; $display("FAIL drive_add_op cycle %0d got %0d want 0", n, ro[n]); end
        if (ri1[n] !== e_op_i1) begin n_bad++; $display("FAIL drive_add_i1 cycle %0d got %h want %h", n, ri1[n], e_op_i1); end
        if (ri2[n] !== e_i2)    begin n_bad++; $display("FAIL drive_add_i2 cycle %0d got %h want %h", n, ri2[n], e_i2); end
      end else begin
        e_op_i1 = ga << k;
        if (ro[n] !== 4'd4)     begin n_bad++; $display("FAIL drive_sll_op cycle %0d got %0d want 4", n, ro[n]); end
        if (ri1[n] !== e_op_i1) begin n_bad++; $display("FAIL drive_sll_i1 cycle %0d got %h want %h", n, ri1[n], e_op_i1); end
        if (ri2[n] !== 32'd1)   begin n_bad++; $display("FAIL drive_sll_i2 cycle %0d got %h want 1", n, ri2[n]); end
      end
    end
    n_cmp += 4;
    if (ro[65] !== 4'd0)   begin n_bad++; $display("FAIL drive_done_op got %0d want 0", ro[65]); end
    if (ri1[65] !== 32'h0) begin n_bad++; $display("FAIL drive_done_i1 got %h want 0", ri1[65]); end
    if (ri2[65] !== 32'h0) begin n_bad++; $display("FAIL drive_done_i2 got %h want 0", ri2[65]); end
    if (rp[65] !== e_prod) begin n_bad++; $display("FAIL drive_prod got %h want %h", rp[65], e_prod); end
  endtask

  task automatic test_back_to_back;
    int dcnt = 0;
    // start held high; operands change mid-flight and are picked up only by the second op
    run_op(32'd5, 32'd6, 140, 67, 30, 32'h0000_0100, 32'h0000_0010, 0);
    for (int n = 1; n <= 140; n++) if (rd[n] === 1'b1) dcnt++;
    n_cmp += 10;
    if (rd[65] !== 1'b1)          begin n_bad++; $display("FAIL b2b_done1 got %b want 1", rd[65]); end
    if (rp[65] !== 32'd30)        begin n_bad++; $display("FAIL b2b_prod1 got %h want 1e", rp[65]); end
    if (rb[66] !== 1'b0)          begin n_bad++; $display("FAIL b2b_idle_busy got %b want 0", rb[66]); end
    if (rd[66] !== 1'b0)          begin n_bad++; $display("FAIL b2b_idle_done got %b want 0", rd[66]); end
    if (rb[67] !== 1'b1)          begin n_bad++; $display("FAIL b2b_busy2_first got %b want 1", rb[67]); end
    if (rb[130] !== 1'b1)         begin n_bad++; $display("FAIL b2b_busy2_last got %b want 1", rb[130]); end
    if (rp[100] !== 32'd30)       begin n_bad++; $display("FAIL b2b_prod_held got %h want 1e", rp[100]); end
    if (rd[131] !== 1'b1)         begin n_bad++; $display("FAIL b2b_done2 got %b want 1", rd[131]); end
    if (rp[131] !== 32'h0000_1000) begin n_bad++; $display("FAIL b2b_prod2 got %h want 00001000", rp[131]); end
    if (dcnt !== 2)               begin n_bad++; $display("FAIL b2b_done_count got %0d want 2", dcnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_busy();
    test_reset_mid();
    test_alu_drive();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
